// File: rtl/counter_pkg.sv
// Shared counter definitions: state encoding and default width used by the
// down-counter and the up-counter bench.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter/timer with optional auto-reload and a
// one-cycle terminal-count pulse whenever Q is written to 0 while running.
module sync_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] reload_r, reload_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             tc_r, tc_s;
  logic             busy_r, done_r;

  // Next-state/datapath decode in priority order: load > stop > start > counting.
  always_comb begin
    state_s  = state_r;
    reload_s = reload_r;
    q_s      = q_r;
    tc_s     = 1'b0;
    if (load) begin
      reload_s = load_val;
      q_s      = load_val;
      state_s  = IDLE;
    end else if (stop && (state_r == RUN)) begin
      state_s = IDLE;
    end else if (start) begin
      q_s     = reload_r;
      state_s = RUN;
      tc_s    = (reload_r == ZERO);
    end else if ((state_r == RUN) && en) begin
      if (q_r != ZERO) begin
        q_s  = q_r - ONE;
        tc_s = (q_r == ONE);
      end else if (auto_reload) begin
        // Zero reload value keeps tc asserted every enabled cycle.
        q_s  = reload_r;
        tc_s = (reload_r == ZERO);
      end else begin
        state_s = DONE;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, reload and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      reload_r <= ZERO;
      q_r      <= ZERO;
      tc_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      reload_r <= reload_s;
      q_r      <= q_s;
      tc_r     <= tc_s;
      busy_r   <= (state_s == RUN);
      done_r   <= (state_s == DONE);
    end
  end

  assign Q    = q_r;
  assign tc   = tc_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
